// File: rtl/uart_tx_frame_if.sv
// Parallel-side bundle of the UART transmit framer: payload request, frame options,
// and the registered serial line / busy flag going back out.
interface uart_tx_frame_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  Data_Valid;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic                  TX_OUT;
   logic                  busy;

   // master: FIFO/synchroniser side presenting the byte; slave: the framer itself.
   modport master (
      output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
      input  TX_OUT, busy
   );

   modport slave (
      input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
      output TX_OUT, busy
   );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, LSB-first data, optional parity, stop; one clk per bit.
// Parity bit and PARITY state exist only when UART_TX_PARITY_EN is defined.
module uart_tx_frame #(
   parameter int DATA_WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   uart_tx_frame_if.slave tx_if
);

   localparam int                CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] ST_PARITY = 3'd4;
`endif

   logic [2:0]            state_q;
   logic [2:0]            state_d;
   logic [CNT_W-1:0]      cnt_q;
   logic [DATA_WIDTH-1:0] shreg_q;
   logic                  tx_out_d;
   logic                  tx_out_q;
   logic                  busy_q;
   logic                  accept;

   // Data_Valid only matters in IDLE; anywhere else it is simply dropped.
   assign accept = (state_q == ST_IDLE) && tx_if.Data_Valid;

`ifdef UART_TX_PARITY_EN
   logic par_en_q;
   logic par_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_en_q <= 1'b0;
         par_q    <= 1'b0;
      end else if (accept) begin
         par_en_q <= tx_if.PAR_EN;
         par_q    <= tx_if.PAR_TYP ? ~^tx_if.P_DATA : ^tx_if.P_DATA;
      end
   end
`else
   logic unused_par_inputs;
   assign unused_par_inputs = tx_if.PAR_EN | tx_if.PAR_TYP;
`endif

   always_comb begin
      // NOTE: default every always_comb output first so no path leaves it unassigned (latch).
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (tx_if.Data_Valid) state_d = ST_START;
         ST_START: state_d = ST_DATA;
         ST_DATA: begin
            if (cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
               state_d = par_en_q ? ST_PARITY : ST_STOP;
`else
               state_d = ST_STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: state_d = ST_STOP;
`endif
         ST_STOP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // The line register lags the state by one edge, so each state's bit appears
   // on the edge that leaves it and TX_OUT never depends combinationally on inputs.
   always_comb begin
      tx_out_d = 1'b1;
      case (state_q)
         ST_START:  tx_out_d = 1'b0;
         ST_DATA:   tx_out_d = shreg_q[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: tx_out_d = par_q;
`endif
         default:   tx_out_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         shreg_q  <= '0;
         tx_out_q <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
         state_q  <= state_d;
         tx_out_q <= tx_out_d;
         busy_q   <= (state_q != ST_IDLE);
         if (accept) begin
            shreg_q <= tx_if.P_DATA;
            cnt_q   <= '0;
         end else if (state_q == ST_DATA) begin
            shreg_q <= shreg_q >> 1;
            cnt_q   <= (cnt_q == LAST_BIT) ? '0 : cnt_q + 1'b1;
         end
      end
   end

   assign tx_if.TX_OUT = tx_out_q;
   assign tx_if.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: table of frames plus reset and back-to-back sequences.
// Expected frames follow the UART_TX_PARITY_EN setting the bench is compiled with.
module tb_uart_tx_frame;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_miss;

   uart_tx_frame_if #(.DATA_WIDTH(8)) tx_if ();

   uart_tx_frame #(.DATA_WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .tx_if (tx_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  data;
      logic        par_en;
      logic        par_typ;
      logic [11:0] exp;   // line bits, first transmitted at exp[len-1]
      int          len;
   } vec_t;

   vec_t vecs[5];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Walks one frame edge by edge after the accept edge, then the first idle edge.
   // At bit poke_at the payload is scrambled and Data_Valid raised; unless hold_dv,
   // Data_Valid drops again one bit later.
   task automatic check_frame(input string tag, input logic [11:0] exp, input int len,
                              input int poke_at, input logic [7:0] poke_data,
                              input logic hold_dv);
      for (int k = 0; k < len; k++) begin
         tick();
         check($sformatf("%s tx bit%0d", tag, k), tx_if.TX_OUT, exp[len-1-k]);
         check($sformatf("%s busy bit%0d", tag, k), tx_if.busy, 1'b1);
         if (k == poke_at) begin
            tx_if.P_DATA     = poke_data;
            tx_if.Data_Valid = 1'b1;
         end else if (k == poke_at + 1 && !hold_dv) begin
            tx_if.Data_Valid = 1'b0;
         end
      end
      tick();
      check($sformatf("%s idle tx", tag), tx_if.TX_OUT, 1'b1);
      check($sformatf("%s idle busy", tag), tx_if.busy, 1'b0);
   endtask

   initial begin
      logic [4:0]  pre_d3;
      logic [11:0] exp_3c;
      int          len_3c;

      n_vec  = 0;
      n_miss = 0;
      pre_d3 = 5'b01010;   // start, D0..D3 of 0xA5

`ifdef UART_TX_PARITY_EN
      vecs[0] = '{8'hA5, 1'b1, 1'b0, 12'b0_01010010101, 11};
      vecs[1] = '{8'hA5, 1'b1, 1'b1, 12'b0_01010010111, 11};
      vecs[2] = '{8'h07, 1'b1, 1'b0, 12'b0_01110000011, 11};
      vecs[3] = '{8'h00, 1'b0, 1'b0, 12'b00_0000000001, 10};
      vecs[4] = '{8'hFF, 1'b1, 1'b1, 12'b0_01111111111, 11};
      exp_3c  = 12'b0_00011110001;
      len_3c  = 11;
`else
      vecs[0] = '{8'hA5, 1'b1, 1'b0, 12'b00_0101001011, 10};
      vecs[1] = '{8'hA5, 1'b1, 1'b1, 12'b00_0101001011, 10};
      vecs[2] = '{8'h07, 1'b1, 1'b0, 12'b00_0111000001, 10};
      vecs[3] = '{8'h00, 1'b0, 1'b0, 12'b00_0000000001, 10};
      vecs[4] = '{8'hFF, 1'b1, 1'b1, 12'b00_0111111111, 10};
      exp_3c  = 12'b00_0001111001;
      len_3c  = 10;
`endif

      rst_n            = 1'b0;
      tx_if.P_DATA     = 8'h00;
      tx_if.Data_Valid = 1'b0;
      tx_if.PAR_EN     = 1'b0;
      tx_if.PAR_TYP    = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("reset tx", tx_if.TX_OUT, 1'b1);
      check("reset busy", tx_if.busy, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      tick();
      check("post-reset tx", tx_if.TX_OUT, 1'b1);

      // Table of frames; each also sees a mid-frame Data_Valid pulse and payload change.
      for (int i = 0; i < 5; i++) begin
         tx_if.P_DATA     = vecs[i].data;
         tx_if.PAR_EN     = vecs[i].par_en;
         tx_if.PAR_TYP    = vecs[i].par_typ;
         tx_if.Data_Valid = 1'b1;
         tick();
         check($sformatf("v%0d accept tx", i), tx_if.TX_OUT, 1'b1);
         check($sformatf("v%0d accept busy", i), tx_if.busy, 1'b0);
         tx_if.Data_Valid = 1'b0;
         check_frame($sformatf("v%0d", i), vecs[i].exp, vecs[i].len, 4, ~vecs[i].data, 1'b0);
         tick();
         check($sformatf("v%0d no queued tx", i), tx_if.TX_OUT, 1'b1);
         check($sformatf("v%0d no queued busy", i), tx_if.busy, 1'b0);
      end

      // Reset asserted during D3 of 0xA5: line and busy must drop out at once.
      tx_if.P_DATA     = 8'hA5;
      tx_if.PAR_EN     = 1'b1;
      tx_if.PAR_TYP    = 1'b0;
      tx_if.Data_Valid = 1'b1;
      tick();
      tx_if.Data_Valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("rst-seq tx bit%0d", k), tx_if.TX_OUT, pre_d3[4-k]);
      end
      rst_n = 1'b0;
      #1;
      check("mid-frame reset tx", tx_if.TX_OUT, 1'b1);
      check("mid-frame reset busy", tx_if.busy, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         check($sformatf("after reset tx%0d", k), tx_if.TX_OUT, 1'b1);
         check($sformatf("after reset busy%0d", k), tx_if.busy, 1'b0);
      end

      // Data_Valid held high, payload switched to 0x3C mid-frame: first frame keeps 0xA5,
      // one idle cycle (also the accept edge), then the 0x3C frame.
      tx_if.P_DATA     = 8'hA5;
      tx_if.PAR_EN     = 1'b1;
      tx_if.PAR_TYP    = 1'b0;
      tx_if.Data_Valid = 1'b1;
      tick();
      check_frame("b2b first", vecs[0].exp, vecs[0].len, 3, 8'h3C, 1'b1);
      tx_if.Data_Valid = 1'b0;
      check_frame("b2b second", exp_3c, len_3c, -1, 8'h3C, 1'b0);
      tick();
      check("b2b end tx", tx_if.TX_OUT, 1'b1);
      check("b2b end busy", tx_if.busy, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

UART transmit framer that serialises one parallel byte per request into start, data (LSB first), optional parity and stop bits on a single line. It is the transmit counterpart of the UART RX parity checker and uses the same parity convention, so a frame it emits passes that checker. It sits between the TX FIFO/synchroniser (which presents `P_DATA` and `Data_Valid`) and the pad. `clk` is the TX bit clock: one clock cycle per line bit.

## Interface
- `DATA_WIDTH`, default 8: payload bits per frame.
- `clk`  in  1  TX bit clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `P_DATA`  in  DATA_WIDTH  parallel payload; sampled only on the accept edge.
- `Data_Valid`  in  1  payload request; accepted only in IDLE.
- `PAR_EN`  in  1  1 = append parity bit; sampled on the accept edge.
- `PAR_TYP`  in  1  0 = even, 1 = odd; sampled on the accept edge.
- `TX_OUT`  out  1  serial line, registered; idle level 1.
- `busy`  out  1  registered; high while a frame is on the line.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: `TX_OUT`=1, `busy`=0. On an edge with `Data_Valid`=1, latch `P_DATA`, `PAR_EN`, `PAR_TYP`, compute parity and go to START.
- Parity of latched data: even → `^data`; odd → `~^data`.
- START: `TX_OUT`=0 for one cycle → DATA.
- DATA: drive `data[i]`, i = 0..DATA_WIDTH-1, one per cycle; counter width clog2(DATA_WIDTH). After the last bit → PARITY if latched `PAR_EN`=1, else STOP.
- PARITY: drive the latched parity bit for one cycle → STOP.
- STOP: `TX_OUT`=1 for one cycle → IDLE.
- `Data_Valid` outside IDLE is ignored: it is not queued, and it does not corrupt the frame. Changes to `P_DATA`/`PAR_*` mid-frame have no effect.
- `Data_Valid` held high continuously: the next frame is accepted on the first edge sampled in IDLE.
- Reset (any time, including mid-frame): immediately `TX_OUT`=1, `busy`=0, state IDLE, counter 0, latched data 0. No partial frame resumes.

## Timing
- Accept on edge 0. Edge 1: `TX_OUT`=0 (start), `busy`=1.
- Edges 1+1..1+DATA_WIDTH: data bits D0..D(N-1).
- Parity bit on edge DATA_WIDTH+2, when enabled.
- Stop bit on edge DATA_WIDTH+2 without parity, or DATA_WIDTH+3 with parity.
- Next edge: IDLE, `busy`=0, `TX_OUT`=1.
- `busy` is high for exactly 10 cycles (8-bit, no parity) or 11 cycles (with parity).
- `Data_Valid` is not sampled on the STOP→IDLE edge. There is a minimum of 1 idle cycle (`TX_OUT`=1) between frames, so the back-to-back period is 11 or 12 cycles.
- `TX_OUT` and `busy` are flop outputs. No combinational path from inputs to outputs.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state and parity logic are present, and behaviour is as above.
- Not defined:
  - PARITY state, parity register and parity logic are compiled out.
  - `PAR_EN` and `PAR_TYP` ports remain but are ignored.
  - Every frame is start + DATA_WIDTH data bits + stop, and `busy` is high for DATA_WIDTH+2 cycles.

## Test plan
- Reset mid-frame: assert `rst_n`=0 during bit D3 → `TX_OUT`=1 and `busy`=0 asynchronously. After release, the line stays 1 until a new `Data_Valid`.
- `P_DATA`=0xA5, `PAR_EN`=1, `PAR_TYP`=0 → line 0,1,0,1,0,0,1,0,1,0,1. Parity bit is 0, `busy` high 11 cycles.
- `P_DATA`=0xA5, `PAR_TYP`=1 → same frame with parity bit 1. `P_DATA`=0x07, even parity → parity bit 1.
- `P_DATA`=0x00, `PAR_EN`=0 → line 0, eight 0s, 1. `busy` high 10 cycles, then IDLE.
- `Data_Valid` held high with `P_DATA` changed to 0x3C mid-frame → first frame carries the original byte unchanged. Exactly 1 idle cycle at 1, then the 0x3C frame starts.
- Build without `UART_TX_PARITY_EN`, `PAR_EN`=1, `P_DATA`=0xFF → 10-cycle frame 0, eight 1s, 1, with no parity bit.
